// File: rtl/vga_param_controller_if.sv
// vga_param_controller_if: pixel request channel between the VGA engine (master) and a pixel source (slave)
interface vga_param_controller_if #(
  parameter int COLOR_BITS = 4
);
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic pix_req;
  logic [3*COLOR_BITS-1:0] pix_rgb;
  modport master (output pix_x, pix_y, pix_req, input pix_rgb);
  modport slave (input pix_x, pix_y, pix_req, output pix_rgb);
endinterface

// File: rtl/vga_param_controller.sv
// vga_param_controller: parametrised VGA timing/pixel engine; define VGA_TESTPATTERN_EN to add the colour-bar source
module vga_param_controller #(
  parameter int CLK_DIV = 2,
  parameter int COLOR_BITS = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input logic clk,
  input logic resetbutton,
  input logic pattern_sel,
  vga_param_controller_if.master pix,
  output logic [COLOR_BITS-1:0] VGA_RED,
  output logic [COLOR_BITS-1:0] VGA_GREEN,
  output logic [COLOR_BITS-1:0] VGA_BLUE,
  output logic VGA_HSYNC,
  output logic VGA_VSYNC,
  output logic frame_start
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = 3 * COLOR_BITS;
  localparam logic [12:0] H_LAST = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [12:0] V_LAST = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [12:0] HS0 = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS1 = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS0 = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS1 = 13'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt;
  logic [11:0] h_cnt, v_cnt;
  logic [12:0] h_ext, v_ext;
  logic tick, h_last, v_last, active, hsync_int, vsync_int;
  logic [CW-1:0] src;
  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign h_last = h_ext == H_LAST;
  assign v_last = v_ext == V_LAST;
  assign active = h_ext < 13'(H_ACTIVE) && v_ext < 13'(V_ACTIVE);
  assign hsync_int = h_ext >= HS0 && h_ext < HS1;
  assign vsync_int = v_ext >= VS0 && v_ext < VS1;
  assign pix.pix_x = h_cnt;
  assign pix.pix_y = v_cnt;
  assign pix.pix_req = active;
`ifdef VGA_TESTPATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;
  // bar index is the number of bar boundaries already passed; the last bar takes the remainder
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (h_ext >= 13'(k * BAR_W)) bar = 3'(k);
  end
  assign src = pattern_sel
    ? {{COLOR_BITS{~bar[1]}}, {COLOR_BITS{~bar[2]}}, {COLOR_BITS{~bar[0]}}}
    : pix.pix_rgb;
`else
  logic unused_sel;
  assign unused_sel = pattern_sel;
  assign src = pix.pix_rgb;
`endif
  // pixel divider, raster counters and the tick-loaded output stage
  always_ff @(posedge clk) begin
    if (resetbutton) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      {VGA_RED, VGA_GREEN, VGA_BLUE} <= '0;
      VGA_HSYNC <= ~HSYNC_POL;
      VGA_VSYNC <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      frame_start <= tick && h_last && v_last;
      if (tick) begin
        h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
        if (h_last) v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
        {VGA_RED, VGA_GREEN, VGA_BLUE} <= active ? src : '0;
        VGA_HSYNC <= hsync_int ? HSYNC_POL : ~HSYNC_POL;
        VGA_VSYNC <= vsync_int ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end
endmodule

// File: doc/vga_param_controller.md
# vga_param_controller

Parametrised VGA timing and pixel-output engine, successor to the fixed-mode 1-bit VGA controller. It derives a pixel tick from the system clock, generates horizontal and vertical counters, sync pulses of configurable polarity and multi-bit RGB. RGB comes either from an external pixel source through a request interface or from a built-in colour-bar generator. It sits between the board clock/reset and the VGA DAC pins.

## Interface
- CLK_DIV, 2: system clocks per pixel (≥1); 50 MHz/2 = 25 MHz pixel clock.
- COLOR_BITS, 4: bits per colour channel.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- HSYNC_POL, 0 / VSYNC_POL, 0: active sync level (0 = active-low).
- clk  in  1  system clock, all logic on rising edge.
- resetbutton  in  1  reset, synchronous, active-high.
- pattern_sel  in  1  1 = internal colour bars, 0 = external pixels.
- pix_rgb  in  3*COLOR_BITS  external pixel {R,G,B}.
- pix_x  out  12  current column counter (combinational from registered counters).
- pix_y  out  12  current row counter.
- pix_req  out  1  high while (pix_x,pix_y) is in the active area.
- VGA_RED / VGA_GREEN / VGA_BLUE  out  COLOR_BITS each  registered colour.
- VGA_HSYNC / VGA_VSYNC  out  1  registered syncs.
- frame_start  out  1  one-clk pulse at start of each frame.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1; tick = (div_cnt == CLK_DIV-1). CLK_DIV=1 → tick every clock.
- On tick: h_cnt increments, wraps H_TOTAL-1→0 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP). On h wrap v_cnt increments, wraps V_TOTAL-1→0.
- Active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; pix_req = active.
- hsync_int = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync_int = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Output stage, loaded on tick: RGB = active ? source : 0; VGA_HSYNC = hsync_int ? HSYNC_POL : ~HSYNC_POL; likewise VSYNC.
- Source: pix_rgb when pattern_sel=0; colour bar when pattern_sel=1 (macro present).
- Colour bars: 8 bars, bar k covers pix_x ≥ k*(H_ACTIVE/8) (integer, elaboration-time); order white, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or zero. Last bar absorbs remainder.
- frame_start registered: 1 for the clock after the tick at which h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- pattern_sel may change at any time; takes effect at the next tick.

## Timing
- Reset: div_cnt=h_cnt=v_cnt=0; RGB=0; syncs at inactive level; frame_start=0. Next clock pix_x=0, pix_y=0, pix_req=1.
- Reset mid-frame: counters return to 0 on the reset edge regardless of state; output stage cleared; no frame_start for the aborted frame.
- Pixel latency: pix_rgb sampled at the clock edge where tick=1 for (pix_x,pix_y); shown on outputs from that edge for CLK_DIV clocks. Syncs delayed identically, so they stay aligned with colour.
- Source must hold pix_rgb stable across the sampling edge; no back-pressure.
- Counter widths 12 bits; H_TOTAL, V_TOTAL ≤ 4096.

## Configuration
- VGA_TESTPATTERN_EN defined: colour-bar generator compiled in, pattern_sel selects the source.
- Undefined: generator absent; pattern_sel ignored; source always pix_rgb.

## Test plan
- Reset: resetbutton high 3 clks → RGB=0, VGA_HSYNC=VGA_VSYNC=1, frame_start=0, then pix_x=0, pix_y=0, pix_req=1.
- Default timing: VGA_HSYNC low 192 clks every 1600 clks; VGA_VSYNC low 3200 clks every 840000 clks; frame_start period 840000 clks.
- External pixels, pattern_sel=0, pix_rgb={pix_x[3:0],pix_y[3:0],4'hA} → outputs match value CLK_DIV clks later in active area, 0 during blanking.
- Colour bars (VGA_TESTPATTERN_EN), pattern_sel=1 → pix_x 0–79 RGB=F,F,F; 80–159 F,F,0; 560–639 0,0,0. Without macro → output follows pix_rgb.
- Mid-frame reset: assert for 1 clk at v=100,h=300 → counters 0,0 next clk; syncs inactive; first frame_start 840000 clks later.
- CLK_DIV=1, HSYNC_POL=1, small timing H 8/2/2/2, V 4/1/1/1 → HSYNC high 2 clks every 14 clks; VSYNC high 14 clks every 98 clks.
